// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: port A, port B and data-memory signals of the shared memory controller
// Port A: a_req/a_we/a_addr/a_wdata in, a_done/a_err/a_rdata out (16-bit load/store)
// Port B: b_req/b_we/b_addr/b_wdata in, b_done/b_err/b_rdata out (32-bit push/pop)
// Memory: mem_addr/mem_din/mem_read/mem_write out, mem_dout in
// slave is the controller view, master is the requester/memory side
interface data_mem_ctrl_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_done;
  logic        a_err;
  logic [15:0] a_rdata;
  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_done;
  logic        b_err;
  logic [31:0] b_rdata;
  logic [31:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_dout;
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dout,
    input  a_done, a_err, a_rdata, b_done, b_err, b_rdata, mem_addr, mem_din, mem_read, mem_write
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_dout,
    output a_done, a_err, a_rdata, b_done, b_err, b_rdata, mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: round-robin sequencer sharing a 16-bit data memory between port A and port B
// clk, rst : clock and asynchronous active-high reset
// bus      : slave view of data_mem_ctrl_if (port A, port B, memory signals)
module data_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 2048
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACC_A    = 2'd1;
  localparam logic [1:0] ACC_B_HI = 2'd2;
  localparam logic [1:0] ACC_B_LO = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [15:0] wlo_q, wlo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        a_done_q, a_done_d;
  logic        a_err_q, a_err_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic        b_done_q, b_done_d;
  logic        b_err_q, b_err_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        a_elig, b_elig, grant_a, grant_b, a_bad, b_bad;
  // a port whose done is showing is still finishing its handshake, so it cannot win
  assign a_elig  = bus.a_req && !a_done_q;
  assign b_elig  = bus.b_req && !b_done_q;
  // last_q = 1 means B was granted last, so A has priority on conflict
  assign grant_b = b_elig && (!a_elig || !last_q);
  assign grant_a = a_elig && !grant_b;
  assign a_bad   = bus.a_addr >= MEM_WORDS;
  // B touches addr and addr+1, so the top word alone is already out of range
  assign b_bad   = bus.b_addr >= MEM_WORDS - 1;
  // strobes are decided at grant and carried through the B halves via mem_*_q,
  // so an out-of-range transfer simply never raises them
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    err_d       = err_q;
    wlo_d       = wlo_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    a_done_d    = 1'b0;
    a_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_done_d    = 1'b0;
    b_err_d     = 1'b0;
    b_rdata_d   = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_b) begin
          state_d     = ACC_B_HI;
          last_d      = 1'b1;
          err_d       = b_bad;
          wlo_d       = bus.b_wdata[15:0];
          mem_addr_d  = bus.b_addr;
          mem_din_d   = bus.b_wdata[31:16];
          mem_read_d  = !bus.b_we && !b_bad;
          mem_write_d = bus.b_we && !b_bad;
        end else if (grant_a) begin
          state_d     = ACC_A;
          last_d      = 1'b0;
          err_d       = a_bad;
          mem_addr_d  = bus.a_addr;
          mem_din_d   = bus.a_wdata;
          mem_read_d  = !bus.a_we && !a_bad;
          mem_write_d = bus.a_we && !a_bad;
        end
      end
      ACC_A: begin
        state_d   = IDLE;
        a_done_d  = 1'b1;
        a_err_d   = err_q;
        a_rdata_d = mem_read_q ? bus.mem_dout : a_rdata_q;
      end
      ACC_B_HI: begin
        state_d     = ACC_B_LO;
        mem_addr_d  = mem_addr_q + 32'd1;
        mem_din_d   = wlo_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (mem_read_q) b_rdata_d[31:16] = bus.mem_dout;
      end
      default: begin
        state_d  = IDLE;
        b_done_d = 1'b1;
        b_err_d  = err_q;
        if (mem_read_q) b_rdata_d[15:0] = bus.mem_dout;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      wlo_q       <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_done_q    <= 1'b0;
      b_err_q     <= 1'b0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      err_q       <= err_d;
      wlo_q       <= wlo_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      a_done_q    <= a_done_d;
      a_err_q     <= a_err_d;
      a_rdata_q   <= a_rdata_d;
      b_done_q    <= b_done_d;
      b_err_q     <= b_err_d;
      b_rdata_q   <= b_rdata_d;
    end
  end
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.a_done    = a_done_q;
  assign bus.a_err     = a_err_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_done    = b_done_q;
  assign bus.b_err     = b_err_q;
  assign bus.b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench for data_mem_ctrl with a word-array reference model
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  data_mem_ctrl_if bus();
  data_mem_ctrl #(.MEM_WORDS(2048)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [15:0] mem_arr [0:2047];
  logic [15:0] ref_mem [0:2047];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int overlap = 0;
  logic [31:0] wr_addr = '0;
  logic [15:0] exp_a_rd;
  logic [31:0] exp_b_rd;
  assign bus.mem_dout = (bus.mem_addr < 32'd2048) ? mem_arr[bus.mem_addr[10:0]] : 16'h0;
  always @(posedge clk) if (bus.mem_write && bus.mem_addr < 32'd2048) mem_arr[bus.mem_addr[10:0]] <= bus.mem_din;
  always @(negedge clk) begin
    if (bus.mem_write) begin wr_cnt++; wr_addr = bus.mem_addr; end
    if (bus.mem_read) rd_cnt++;
    if (bus.mem_read && bus.mem_write) overlap++;
  end
  task automatic do_a(input logic we, input logic [31:0] addr, input logic [15:0] wd, output int lat, output int nw, output int nr);
    int w0, r0;
    @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd; bus.a_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.a_done) begin lat = i; break; end
    end
    bus.a_req = 1'b0;
    nw = wr_cnt - w0; nr = rd_cnt - r0;
  endtask
  task automatic do_b(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int lat, output int nw, output int nr);
    int w0, r0;
    @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd; bus.b_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.b_done) begin lat = i; break; end
    end
    bus.b_req = 1'b0;
    nw = wr_cnt - w0; nr = rd_cnt - r0;
  endtask
  task automatic apply_reset();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_a_rd = '0; exp_b_rd = '0;
  endtask
  task automatic test_reset();
    apply_reset();
    checks++; if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_din} !== 50'h0) begin errors++; $display("FAIL reset_mem got %b %b %h %h exp 0", bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_din); end
    checks++; if ({bus.a_done, bus.a_err, bus.a_rdata} !== 18'h0) begin errors++; $display("FAIL reset_a got %b %b %h exp 0", bus.a_done, bus.a_err, bus.a_rdata); end
    checks++; if ({bus.b_done, bus.b_err, bus.b_rdata} !== 34'h0) begin errors++; $display("FAIL reset_b got %b %b %h exp 0", bus.b_done, bus.b_err, bus.b_rdata); end
  endtask
  task automatic test_port_a();
    int lat, nw, nr;
    do_a(1'b1, 32'd1, 16'hFFFF, lat, nw, nr);
    ref_mem[1] = 16'hFFFF;
    checks++; if (lat !== 2) begin errors++; $display("FAIL a_store_lat got %0d exp 2", lat); end
    checks++; if (nw !== 1 || nr !== 0 || wr_addr !== 32'd1) begin errors++; $display("FAIL a_store_strobe got w%0d r%0d addr %0d exp w1 r0 addr 1", nw, nr, wr_addr); end
    do_a(1'b0, 32'd1, 16'h0, lat, nw, nr);
    exp_a_rd = ref_mem[1];
    checks++; if (lat !== 2) begin errors++; $display("FAIL a_load_lat got %0d exp 2", lat); end
    checks++; if (bus.a_rdata !== exp_a_rd || bus.a_err !== 1'b0) begin errors++; $display("FAIL a_load_data got %h err %b exp %h err 0", bus.a_rdata, bus.a_err, exp_a_rd); end
  endtask
  task automatic test_port_b();
    int lat, nw, nr;
    do_b(1'b1, 32'd8, 32'h0DDF_1234, lat, nw, nr);
    ref_mem[8] = 16'h0DDF; ref_mem[9] = 16'h1234;
    checks++; if (lat !== 3 || nw !== 2 || nr !== 0) begin errors++; $display("FAIL b_push got lat %0d w%0d r%0d exp lat 3 w2 r0", lat, nw, nr); end
    checks++; if (mem_arr[8] !== 16'h0DDF || mem_arr[9] !== 16'h1234) begin errors++; $display("FAIL b_push_mem got %h %h exp 0ddf 1234", mem_arr[8], mem_arr[9]); end
    do_b(1'b0, 32'd8, 32'h0, lat, nw, nr);
    exp_b_rd = 32'h0DDF_1234;
    checks++; if (lat !== 3 || nr !== 2 || nw !== 0) begin errors++; $display("FAIL b_pop got lat %0d w%0d r%0d exp lat 3 w0 r2", lat, nw, nr); end
    checks++; if (bus.b_rdata !== exp_b_rd || bus.b_err !== 1'b0) begin errors++; $display("FAIL b_pop_data got %h err %b exp %h err 0", bus.b_rdata, bus.b_err, exp_b_rd); end
  endtask
  task automatic test_simultaneous();
    int first, ta, tb;
    logic [15:0] ard;
    logic [31:0] brd;
    apply_reset();
    @(negedge clk);
    bus.a_we = 1'b0; bus.a_addr = 32'd8; bus.a_req = 1'b1;
    bus.b_we = 1'b0; bus.b_addr = 32'd8; bus.b_req = 1'b1;
    first = -1; ta = -1; tb = -1; ard = '0; brd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.b_done && tb < 0) begin tb = i; brd = bus.b_rdata; bus.b_req = 1'b0; if (first < 0) first = 1; end
      if (bus.a_done && ta < 0) begin ta = i; ard = bus.a_rdata; bus.a_req = 1'b0; if (first < 0) first = 0; end
      if (ta > 0 && tb > 0) break;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    exp_a_rd = ref_mem[8]; exp_b_rd = {ref_mem[8], ref_mem[9]};
    checks++; if (first !== 1 || tb !== 3 || ta !== 5) begin errors++; $display("FAIL conflict_order got first %0d tb %0d ta %0d exp 1 3 5", first, tb, ta); end
    checks++; if (ard !== exp_a_rd || brd !== exp_b_rd) begin errors++; $display("FAIL conflict_data got %h %h exp %h %h", ard, brd, exp_a_rd, exp_b_rd); end
  endtask
  task automatic test_back_to_back();
    int seq[$];
    int tim[$];
    int bad;
    @(negedge clk);
    bus.a_we = 1'b0; bus.a_addr = 32'd0; bus.a_req = 1'b1;
    bus.b_we = 1'b0; bus.b_addr = 32'd0; bus.b_req = 1'b1;
    for (int i = 1; i <= 60 && seq.size() < 8; i++) begin
      @(negedge clk);
      if (bus.a_done) begin seq.push_back(0); tim.push_back(i); end
      if (bus.b_done) begin seq.push_back(1); tim.push_back(i); end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk);
    exp_a_rd = ref_mem[0]; exp_b_rd = {ref_mem[0], ref_mem[1]};
    checks++; if (seq.size() !== 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", seq.size()); end
    bad = 0;
    for (int i = 0; i < seq.size(); i++) begin
      if (seq[i] != ((i % 2 == 0) ? 1 : 0)) bad++;
      if (i > 0 && tim[i] - tim[i-1] != (seq[i] == 1 ? 3 : 2)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_alternate got %0d bad slots exp 0", bad); end
  endtask
  task automatic test_boundary();
    int lat, nw, nr;
    do_a(1'b1, 32'd2047, 16'hEB5A, lat, nw, nr);
    ref_mem[2047] = 16'hEB5A;
    checks++; if (lat !== 2 || nw !== 1 || wr_addr !== 32'd2047 || bus.a_err !== 1'b0) begin errors++; $display("FAIL a_top_store got lat %0d w%0d addr %0d err %b exp 2 1 2047 0", lat, nw, wr_addr, bus.a_err); end
    do_a(1'b0, 32'd2047, 16'h0, lat, nw, nr);
    exp_a_rd = ref_mem[2047];
    checks++; if (bus.a_rdata !== exp_a_rd || bus.a_err !== 1'b0) begin errors++; $display("FAIL a_top_load got %h err %b exp %h err 0", bus.a_rdata, bus.a_err, exp_a_rd); end
    do_b(1'b0, 32'd2047, 32'h0, lat, nw, nr);
    checks++; if (lat !== 3 || bus.b_err !== 1'b1 || nw + nr !== 0 || bus.b_rdata !== exp_b_rd) begin errors++; $display("FAIL b_top_err got lat %0d err %b strobes %0d rd %h exp 3 1 0 %h", lat, bus.b_err, nw + nr, bus.b_rdata, exp_b_rd); end
    do_a(1'b0, 32'hFFFF_FFFF, 16'h0, lat, nw, nr);
    checks++; if (lat !== 2 || bus.a_err !== 1'b1 || nw + nr !== 0 || bus.a_rdata !== exp_a_rd) begin errors++; $display("FAIL a_max_err got lat %0d err %b strobes %0d rd %h exp 2 1 0 %h", lat, bus.a_err, nw + nr, bus.a_rdata, exp_a_rd); end
    do_b(1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, lat, nw, nr);
    checks++; if (bus.b_err !== 1'b1 || nw + nr !== 0) begin errors++; $display("FAIL b_max_err got err %b strobes %0d exp 1 0", bus.b_err, nw + nr); end
    do_b(1'b1, 32'd2046, 32'h1234_5678, lat, nw, nr);
    ref_mem[2046] = 16'h1234; ref_mem[2047] = 16'h5678;
    do_b(1'b0, 32'd2046, 32'h0, lat, nw, nr);
    exp_b_rd = {ref_mem[2046], ref_mem[2047]};
    checks++; if (bus.b_err !== 1'b0 || bus.b_rdata !== exp_b_rd) begin errors++; $display("FAIL b_top_ok got %h err %b exp %h err 0", bus.b_rdata, bus.b_err, exp_b_rd); end
  endtask
  task automatic test_reset_mid();
    int lat, nw, nr, dn;
    @(negedge clk);
    bus.b_we = 1'b1; bus.b_addr = 32'd4; bus.b_wdata = 32'hAAAA_5555; bus.b_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.b_done, bus.b_rdata, bus.a_rdata} !== 83'h0) begin errors++; $display("FAIL rst_mid_out got w%b r%b addr %h done %b brd %h ard %h exp 0", bus.mem_write, bus.mem_read, bus.mem_addr, bus.b_done, bus.b_rdata, bus.a_rdata); end
    bus.b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_a_rd = '0; exp_b_rd = '0;
    dn = 0;
    repeat (5) begin @(negedge clk); if (bus.b_done) dn++; end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rst_mid_done got %0d pulses exp 0", dn); end
    checks++; if (mem_arr[4] !== 16'hAAAA || mem_arr[5] !== ref_mem[5]) begin errors++; $display("FAIL rst_mid_mem got %h %h exp aaaa %h", mem_arr[4], mem_arr[5], ref_mem[5]); end
    ref_mem[4] = 16'hAAAA;
    do_a(1'b0, 32'd4, 16'h0, lat, nw, nr);
    exp_a_rd = ref_mem[4];
    checks++; if (lat !== 2 || bus.a_rdata !== exp_a_rd || bus.a_err !== 1'b0) begin errors++; $display("FAIL rst_mid_load got lat %0d %h err %b exp 2 %h 0", lat, bus.a_rdata, bus.a_err, exp_a_rd); end
  endtask
  task automatic test_held();
    int w0, lat, dn;
    @(negedge clk);
    w0 = wr_cnt;
    bus.a_we = 1'b1; bus.a_addr = 32'd20; bus.a_wdata = 16'h3C3C; bus.a_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin @(negedge clk); if (bus.a_done) begin lat = i; break; end end
    @(negedge clk);
    bus.a_req = 1'b0;
    dn = 0;
    repeat (4) begin @(negedge clk); if (bus.a_done) dn++; end
    ref_mem[20] = 16'h3C3C;
    checks++; if (lat !== 2 || dn !== 0 || wr_cnt - w0 !== 1) begin errors++; $display("FAIL held_single got lat %0d extra %0d writes %0d exp 2 0 1", lat, dn, wr_cnt - w0); end
    w0 = wr_cnt;
    bus.a_addr = 32'd21; bus.a_wdata = 16'h5A5A; bus.a_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin @(negedge clk); if (bus.a_done) begin lat = i; break; end end
    repeat (2) @(negedge clk);
    bus.a_req = 1'b0;
    dn = 0;
    repeat (5) begin @(negedge clk); if (bus.a_done) dn++; end
    ref_mem[21] = 16'h5A5A;
    checks++; if (lat !== 2 || dn !== 1 || wr_cnt - w0 !== 2) begin errors++; $display("FAIL held_repeat got lat %0d extra %0d writes %0d exp 2 1 2", lat, dn, wr_cnt - w0); end
  endtask
  task automatic test_random();
    int lat, nw, nr, sel, bad;
    logic we, port, oob;
    logic [31:0] addr, wd;
    logic [10:0] ai;
    for (int n = 0; n < 80; n++) begin
      port = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      addr = (sel == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : (sel == 1) ? 32'($urandom_range(2044, 2050)) : 32'($urandom_range(0, 2047));
      wd = $urandom;
      ai = addr[10:0];
      if (!port) begin
        oob = addr > 32'd2047;
        do_a(we, addr, wd[15:0], lat, nw, nr);
        if (!oob && we) ref_mem[ai] = wd[15:0];
        if (!oob && !we) exp_a_rd = ref_mem[ai];
        checks++; if (lat !== 2 || bus.a_err !== oob || bus.a_rdata !== exp_a_rd) begin errors++; $display("FAIL rand_a addr %h we %b got lat %0d err %b rd %h exp 2 %b %h", addr, we, lat, bus.a_err, bus.a_rdata, oob, exp_a_rd); end
        checks++; if (nw !== int'(!oob && we) || nr !== int'(!oob && !we)) begin errors++; $display("FAIL rand_a_strobe addr %h got w%0d r%0d", addr, nw, nr); end
      end else begin
        oob = addr > 32'd2046;
        do_b(we, addr, wd, lat, nw, nr);
        if (!oob && we) begin ref_mem[ai] = wd[31:16]; ref_mem[ai + 11'd1] = wd[15:0]; end
        if (!oob && !we) exp_b_rd = {ref_mem[ai], ref_mem[ai + 11'd1]};
        checks++; if (lat !== 3 || bus.b_err !== oob || bus.b_rdata !== exp_b_rd) begin errors++; $display("FAIL rand_b addr %h we %b got lat %0d err %b rd %h exp 3 %b %h", addr, we, lat, bus.b_err, bus.b_rdata, oob, exp_b_rd); end
        checks++; if (nw !== 2 * int'(!oob && we) || nr !== 2 * int'(!oob && !we)) begin errors++; $display("FAIL rand_b_strobe addr %h got w%0d r%0d", addr, nw, nr); end
      end
    end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_mem_image got %0d differing words exp 0", bad); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap got %0d cycles exp 0", overlap); end
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) begin mem_arr[i] = 16'($urandom); ref_mem[i] = mem_arr[i]; end
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    test_reset();
    test_port_a();
    test_port_b();
    test_simultaneous();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
